// File: rtl/mux_pkg.sv
// Shared types and constants for the packet-aware two-input stream multiplexer.
package mux_pkg;

  localparam int MUX_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } mux_state_e;

endpackage

// File: rtl/mux_stream_sel_if.sv
// Bundle of both input channels and the registered output channel of mux_stream_sel.
interface mux_stream_sel_if #(
  parameter int WIDTH = mux_pkg::MUX_WIDTH_DEFAULT
);

  // Handshake: a beat moves on a rising edge where valid && ready are both 1;
  // a source holds valid/data/last steady until that edge, and ready never
  // depends on the same channel's valid while a packet lock is held.
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             sel_o;

  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last, sel_o
  );

  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last, sel_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; a held packet lock overrides arbitration.
module rr_arb2
  import mux_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  input  mux_state_e state,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    case (state)
      LOCK0: begin
        gnt_valid = 1'b1;
        gnt       = 1'b0;
      end
      LOCK1: begin
        gnt_valid = 1'b1;
        gnt       = 1'b1;
      end
      default: begin
        // ptr names the last winner, so a tie goes to the other channel.
        if (valid0 && valid1) begin
          gnt_valid = 1'b1;
          gnt       = ~ptr;
        end else if (valid0) begin
          gnt_valid = 1'b1;
          gnt       = 1'b0;
        end else if (valid1) begin
          gnt_valid = 1'b1;
          gnt       = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/mux_stream_sel.sv
// Packet-aware 2:1 stream mux: round-robin between packets, lock until last,
// single registered output stage that can drain and load in the same cycle.
module mux_stream_sel
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux_stream_sel_if.slave         bus,
  output mux_state_e              state_dbg
);

  mux_state_e       state;
  mux_state_e       state_nxt;
  logic             ptr;
  logic             gnt_valid;
  logic             gnt;
  logic             space;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             accept;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             sel_q;

  rr_arb2 u_arb (
    .valid0    (bus.in0_valid),
    .valid1    (bus.in1_valid),
    .ptr       (ptr),
    .state     (state),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign space     = ~out_valid_q | bus.out_ready;
  assign sel_valid = gnt ? bus.in1_valid : bus.in0_valid;
  assign sel_last  = gnt ? bus.in1_last  : bus.in0_last;
  assign sel_data  = gnt ? bus.in1_data  : bus.in0_data;
  assign accept    = gnt_valid & sel_valid & space;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b1;
    end else begin
      state <= state_nxt;
      // The pointer only moves when a whole packet has been handed over.
      if (accept && sel_last) begin
        ptr <= gnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (sel_last) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = gnt ? LOCK1 : LOCK0;
      end
    end
  end

  always_comb begin
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    if (rst_n && gnt_valid && space) begin
      bus.in0_ready = ~gnt;
      bus.in1_ready = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_last_q  <= sel_last;
      sel_q       <= gnt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.sel_o     = sel_q;
  assign state_dbg     = state;

endmodule
